// File: rtl/mem_arb_pkg.sv
// Shared helpers and inactive-level constants for the round-robin memory arbiter.
package mem_arb_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Index width never collapses to zero bits, so NPORTS=1 still has a 1-bit id.
   function automatic int idw(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   localparam logic EN_OFF = 1'b1;
   localparam logic WR_OFF = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Request vector + fairness pointer -> one-hot grant, grant index and any-grant flag.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NPORTS     = 4,
   parameter int IDW        = 2,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [NPORTS-1:0] req_i,
   input  logic [IDW-1:0]    ptr_i,
   output logic [NPORTS-1:0] gnt_o,
   output logic [IDW-1:0]    idx_o,
   output logic              any_o
);

   localparam logic [IDW:0] NP = (IDW+1)'(NPORTS);

   logic [IDW-1:0]    shamt;
   logic [NPORTS-1:0] rot;
   logic [IDW-1:0]    off;
   logic [IDW:0]      sum;

   // Rotating the doubled vector puts the pointer's port at bit 0; fixed mode rotates by zero.
   assign shamt = FIXED_PRIO ? '0 : ptr_i;
   assign rot   = NPORTS'({req_i, req_i} >> shamt);

   always_comb begin
      off   = '0;
      any_o = 1'b0;
      for (int k = NPORTS - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off   = IDW'(k);
            any_o = 1'b1;
         end
      end
   end

   always_comb begin
      sum = {1'b0, off} + {1'b0, shamt};
      if (sum >= NP) sum = sum - NP;
   end

   assign idx_o = sum[IDW-1:0];
   assign gnt_o = any_o ? (NPORTS'(1) << idx_o) : '0;

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter in front of one single-ported synchronous data memory,
// with per-port stall and per-port read-return pulses.
module mem_arbiter_rr
   import mem_arb_pkg::*;
#(
   parameter int NPORTS      = 4,
   parameter int PORTW       = 32,
   parameter int ADDRWIDTH   = 15,
   parameter int MEM_LATENCY = 1,
   parameter bit FIXED_PRIO  = 1'b0
) (
   input  logic                        clk,
   input  logic                        rstx,
   input  logic [NPORTS*PORTW-1:0]     d_in,
   input  logic [NPORTS*ADDRWIDTH-1:0] addr_in,
   input  logic [NPORTS-1:0]           en_x_in,
   input  logic [NPORTS-1:0]           wr_x_in,
   input  logic [NPORTS*PORTW-1:0]     bit_wr_x_in,
   output logic [PORTW-1:0]            d,
   output logic [ADDRWIDTH-1:0]        addr,
   output logic                        en_x,
   output logic                        wr_x,
   output logic [PORTW-1:0]            bit_wr_x,
   input  logic [PORTW-1:0]            q,
   output logic [PORTW-1:0]            q_out,
   output logic [NPORTS-1:0]           q_valid,
   output logic [NPORTS-1:0]           busy
);

   localparam int             IDW  = idw(NPORTS);
   localparam logic [IDW-1:0] LAST = IDW'(NPORTS - 1);

   logic [NPORTS-1:0] req;
   logic [NPORTS-1:0] gnt;
   logic [IDW-1:0]    idx;
   logic              any;
   logic              gnt_v;
   logic [IDW-1:0]    ptr_d, ptr_q;
   logic [MEM_LATENCY-1:0] rv_q;
   logic [IDW-1:0]         rid_q [MEM_LATENCY];

   // A master holds en_x_in low until it sees busy low in the same cycle; that cycle is its
   // transfer. A read's data arrives MEM_LATENCY cycles later, flagged by its q_valid bit.
   assign req = ~en_x_in;

   rr_pick #(
      .NPORTS     (NPORTS),
      .IDW        (IDW),
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (idx),
      .any_o (any)
   );

   // Memory side stays inactive for the whole reset, even with requests pending.
   assign gnt_v = any & rstx;

   always_comb begin
      d        = d_in[PORTW-1:0];
      addr     = addr_in[ADDRWIDTH-1:0];
      en_x     = EN_OFF;
      wr_x     = WR_OFF;
      bit_wr_x = '1;
      if (gnt_v) begin
         for (int p = 0; p < NPORTS; p++) begin
            if (gnt[p]) begin
               d        = d_in[p*PORTW +: PORTW];
               addr     = addr_in[p*ADDRWIDTH +: ADDRWIDTH];
               en_x     = 1'b0;
               wr_x     = wr_x_in[p];
               bit_wr_x = bit_wr_x_in[p*PORTW +: PORTW];
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_v) ptr_d = (idx == LAST) ? '0 : idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         ptr_q <= '0;
         rv_q  <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) rid_q[i] <= '0;
      end else begin
         ptr_q    <= ptr_d;
         rv_q[0]  <= gnt_v & wr_x;
         rid_q[0] <= idx;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            rv_q[i]  <= rv_q[i-1];
            rid_q[i] <= rid_q[i-1];
         end
      end
   end

   assign q_out   = q;
   assign q_valid = NPORTS'(rv_q[MEM_LATENCY-1]) << rid_q[MEM_LATENCY-1];
   assign busy    = rstx ? (req & ~gnt) : '0;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: 4 ports, 2-cycle memory, plus a fixed-priority instance.
module tb_mem_arbiter_rr;

   localparam int NP = 4;
   localparam int PW = 32;
   localparam int AW = 15;

   logic            clk;
   logic            rstx;
   logic [NP*PW-1:0] d_in, bit_wr_x_in;
   logic [NP*AW-1:0] addr_in;
   logic [NP-1:0]    en_x_in, wr_x_in;
   logic [PW-1:0]    d, bit_wr_x, q, q_out;
   logic [AW-1:0]    addr;
   logic             en_x, wr_x;
   logic [NP-1:0]    q_valid, busy;

   logic [NP*PW-1:0] fp_d_in, fp_bit_wr_x_in;
   logic [NP*AW-1:0] fp_addr_in;
   logic [NP-1:0]    fp_en_x_in, fp_wr_x_in;
   logic [PW-1:0]    fp_d, fp_bit_wr_x, fp_q_out;
   logic [AW-1:0]    fp_addr;
   logic             fp_en_x, fp_wr_x;
   logic [NP-1:0]    fp_q_valid, fp_busy;

   logic [PW-1:0] mem_p0, mem_p1;
   logic [35:0]   exp_q[$];
   int            n_checks;
   int            n_err;
   int            ptr_m;

   mem_arbiter_rr #(.NPORTS(NP), .PORTW(PW), .ADDRWIDTH(AW), .MEM_LATENCY(2), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rstx(rstx), .d_in(d_in), .addr_in(addr_in), .en_x_in(en_x_in),
      .wr_x_in(wr_x_in), .bit_wr_x_in(bit_wr_x_in), .d(d), .addr(addr), .en_x(en_x),
      .wr_x(wr_x), .bit_wr_x(bit_wr_x), .q(q), .q_out(q_out), .q_valid(q_valid), .busy(busy)
   );

   mem_arbiter_rr #(.NPORTS(NP), .PORTW(PW), .ADDRWIDTH(AW), .MEM_LATENCY(2), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .rstx(rstx), .d_in(fp_d_in), .addr_in(fp_addr_in), .en_x_in(fp_en_x_in),
      .wr_x_in(fp_wr_x_in), .bit_wr_x_in(fp_bit_wr_x_in), .d(fp_d), .addr(fp_addr),
      .en_x(fp_en_x), .wr_x(fp_wr_x), .bit_wr_x(fp_bit_wr_x), .q(q), .q_out(fp_q_out),
      .q_valid(fp_q_valid), .busy(fp_busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory model: 2-cycle read latency ----------------
   function automatic logic [31:0] mem_word(input logic [14:0] a);
      return 32'hDEADBEEF ^ ({17'b0, a ^ 15'h0010} * 32'h9E3779B1);
   endfunction

   always @(posedge clk) begin
      mem_p0 <= mem_word(addr);
      mem_p1 <= mem_p0;
   end
   assign q = mem_p1;

   function automatic logic [31:0] port_data(input int p);
      return 32'hC0DE0000 | 32'(p);
   endfunction

   function automatic logic [31:0] port_mask(input int p);
      return {16'hFFFF, 16'(p ^ 1)};
   endfunction

   function automatic int rr_win(input logic [3:0] req, input int ptr);
      int j;
      for (int k = 0; k < NP; k++) begin
         j = (ptr + k) % NP;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard: every q_valid pulse must match the oldest outstanding read.
   always @(negedge clk) begin
      if (q_valid !== 4'b0000) begin
         if (exp_q.size() == 0) chk("q_unexpected", {28'b0, q_valid}, 64'h0);
         else chk("q_return", {28'b0, q_valid, q_out}, {28'b0, exp_q.pop_front()});
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input logic [3:0] req, input logic [3:0] rd, input logic [14:0] abase,
                        input bit expect_ret);
      int         w;
      logic [3:0] g;
      for (int p = 0; p < NP; p++) begin
         en_x_in[p]                = ~req[p];
         wr_x_in[p]                = rd[p];
         addr_in[p*AW +: AW]       = abase + 15'(p);
         d_in[p*PW +: PW]          = port_data(p);
         bit_wr_x_in[p*PW +: PW]   = port_mask(p);
      end
      w = rr_win(req, ptr_m);
      g = (w < 0) ? 4'b0000 : (4'b0001 << w);
      @(negedge clk);
      if (w < 0) begin
         chk("idle_en_x", {63'b0, en_x}, 64'h1);
         chk("idle_wr_x", {63'b0, wr_x}, 64'h1);
         chk("idle_bit_wr_x", {32'b0, bit_wr_x}, {32'b0, 32'hFFFFFFFF});
      end else begin
         chk("en_x", {63'b0, en_x}, 64'h0);
         chk("addr", {49'b0, addr}, {49'b0, abase + 15'(w)});
         chk("wr_x", {63'b0, wr_x}, {63'b0, rd[w]});
         chk("d", {32'b0, d}, {32'b0, port_data(w)});
         chk("bit_wr_x", {32'b0, bit_wr_x}, {32'b0, port_mask(w)});
         if (rd[w] && expect_ret) exp_q.push_back({g, mem_word(abase + 15'(w))});
         ptr_m = (w + 1) % NP;
      end
      chk("busy", {60'b0, busy}, {60'b0, req & ~g});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(4'b0000, 4'b1111, 15'h0, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_err    = 0;
      ptr_m    = 0;
      rstx     = 1'b0;
      en_x_in  = 4'b0000;
      wr_x_in  = 4'b1111;
      d_in     = '0;
      addr_in  = '0;
      bit_wr_x_in = '1;
      fp_en_x_in  = 4'b1111;
      fp_wr_x_in  = 4'b0000;
      for (int p = 0; p < NP; p++) begin
         fp_addr_in[p*AW +: AW]     = 15'h200 + 15'(p);
         fp_d_in[p*PW +: PW]        = port_data(p);
         fp_bit_wr_x_in[p*PW +: PW] = 32'h0;
      end

      // Reset held with every port requesting: memory side must stay inactive.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_en_x", {63'b0, en_x}, 64'h1);
      chk("rst_wr_x", {63'b0, wr_x}, 64'h1);
      chk("rst_bit_wr_x", {32'b0, bit_wr_x}, {32'b0, 32'hFFFFFFFF});
      chk("rst_busy", {60'b0, busy}, 64'h0);
      chk("rst_q_valid", {60'b0, q_valid}, 64'h0);
      @(posedge clk);
      #1 rstx = 1'b1;

      // All ports read continuously: grants 0,1,2,3,0.
      repeat (5) drive(4'b1111, 4'b1111, 15'h100, 1'b1);
      idle(3);

      // Port 2 alone reads 0x0010 -> 0xDEADBEEF two cycles later.
      drive(4'b0100, 4'b0100, 15'h000E, 1'b1);
      idle(3);

      // Port 3 granted (pointer wraps), then 1 beats 3, then 3.
      drive(4'b1000, 4'b1000, 15'h020, 1'b1);
      drive(4'b1010, 4'b1010, 15'h030, 1'b1);
      drive(4'b1000, 4'b1000, 15'h040, 1'b1);
      idle(3);

      // Port 1 write to 0x0005, then a read that reset must drop.
      drive(4'b0010, 4'b0000, 15'h0004, 1'b1);
      drive(4'b0010, 4'b0010, 15'h0004, 1'b0);
      en_x_in = 4'b1111;
      rstx    = 1'b0;
      @(negedge clk);
      chk("pulse_en_x", {63'b0, en_x}, 64'h1);
      chk("pulse_q_valid", {60'b0, q_valid}, 64'h0);
      @(posedge clk);
      #1 rstx = 1'b1;
      ptr_m = 0;
      idle(4);
      drive(4'b1111, 4'b1111, 15'h300, 1'b1);
      idle(3);

      // Random traffic against the round-robin model.
      for (int i = 0; i < 24; i++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               15'($urandom_range(0, 32000)), 1'b1);
      end
      idle(4);

      // Fixed priority: ports 0 and 2 contend, port 0 always wins.
      fp_en_x_in = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fp_addr", {49'b0, fp_addr}, {49'b0, 15'h200});
         chk("fp_busy", {60'b0, fp_busy}, {60'b0, 4'b0100});
         @(posedge clk);
         #1;
      end
      fp_en_x_in = 4'b1111;

      idle(2);
      chk("sb_empty", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
